// File: rtl/ps2_mouse_tracker.sv
// ---------------------------------------------------------------------------
// ps2_mouse_tracker
//
// Assembles PS/2 mouse packets (3-byte standard or 4-byte IntelliMouse wheel
// format) from the byte stream delivered by PS2_Controller. It also keeps an
// absolute cursor position that is clamped to the screen.
//
// The packet assembler checks sync on byte 0 (bit 3 must be set). A partial
// packet is abandoned when the gap between its bytes grows too long. Decoded
// packet fields are registered one cycle after the final byte. The cursor
// position follows one cycle after that.
//
// Ports:
//   clk           system clock (CLOCK_50 domain)
//   rst_n         asynchronous active-low reset
//   ps2_byte      received byte from PS2_Controller
//   ps2_byte_en   one-cycle strobe, ps2_byte valid
//   clear         synchronous: re-centre cursor, abort partial packet
//   delta_x       signed 9-bit X movement of last packet
//   delta_y       signed 9-bit Y movement of last packet
//   wheel         signed 4-bit wheel movement (0 in 3-byte mode)
//   buttons       {middle,right,left} of last packet
//   ovf           {y_ovf,x_ovf} of last packet
//   packet_valid  one-cycle pulse, packet outputs updated
//   pos_x/pos_y   absolute cursor position
//   pos_update    one-cycle pulse, pos_x/pos_y updated
//   sync_err      one-cycle pulse on dropped byte or inter-byte timeout
// ---------------------------------------------------------------------------
module ps2_mouse_tracker #(
    parameter int PACKET_BYTES   = 3,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int POS_W          = 10,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int INVERT_Y       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       ps2_byte,
    input  logic             ps2_byte_en,
    input  logic             clear,
    output logic [8:0]       delta_x,
    output logic [8:0]       delta_y,
    output logic [3:0]       wheel,
    output logic [2:0]       buttons,
    output logic [1:0]       ovf,
    output logic             packet_valid,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             pos_update,
    output logic             sync_err
);

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        WAIT_B3
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

    // Two guard bits: one absorbs the sign of the delta, one absorbs the carry.
    localparam int SW = POS_W + 2;

    localparam logic [POS_W-1:0] X_LIM = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_LIM = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] X_CTR = POS_W'(X_MAX / 2);
    localparam logic [POS_W-1:0] Y_CTR = POS_W'(Y_MAX / 2);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             drop, timeout, pkt_done;

    // Byte 0 is held as its individual fields. Bit 3 (the sync bit) is
    // known to be set and so is not stored.
    logic [1:0] b0_ovf;
    logic       b0_ys, b0_xs;
    logic [2:0] b0_btn;
    logic [7:0] b1, b2;

    // ------------------------------------------------------------------
    // Packet assembler: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default before any branch.
    // A path that leaves one unassigned would infer a latch.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        drop     = 1'b0;
        timeout  = 1'b0;
        pkt_done = 1'b0;
        if (clear) begin
            // clear overrides a coincident strobe; that byte is discarded
            state_n = WAIT_B0;
            cnt_n   = '0;
        end else if (state == WAIT_B0) begin
            cnt_n = '0;
            if (ps2_byte_en) begin
                if (ps2_byte[3]) state_n = WAIT_B1;
                else             drop    = 1'b1;
            end
        end else if (ps2_byte_en) begin
            // a strobe on the limit cycle wins over the timeout
            cnt_n = '0;
            case (state)
                WAIT_B1: state_n = WAIT_B2;
                WAIT_B2: begin
                    if (PACKET_BYTES == 4) begin
                        state_n = WAIT_B3;
                    end else begin
                        state_n  = WAIT_B0;
                        pkt_done = 1'b1;
                    end
                end
                default: begin
                    state_n  = WAIT_B0;
                    pkt_done = 1'b1;
                end
            endcase
        end else if (cnt == CNT_LIM) begin
            state_n = WAIT_B0;
            cnt_n   = '0;
            timeout = 1'b1;
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values no matter what order the blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_B0;
            cnt      <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sync_err <= drop | timeout;
        end
    end

    // NOTE: the byte holding registers have no reset. A byte is always
    // written before the packet that uses it completes, so a reset value
    // would never be seen.
    always_ff @(posedge clk) begin
        if (ps2_byte_en && !clear) begin
            case (state)
                WAIT_B0: begin
                    if (ps2_byte[3]) begin
                        b0_ovf <= ps2_byte[7:6];
                        b0_ys  <= ps2_byte[5];
                        b0_xs  <= ps2_byte[4];
                        b0_btn <= ps2_byte[2:0];
                    end
                end
                WAIT_B1: b1 <= ps2_byte;
                WAIT_B2: b2 <= ps2_byte;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packet output register (N+1)
    // ------------------------------------------------------------------
    // In 3-byte mode the Y byte is the final byte, still on the input bus.
    logic [7:0] y_lo;
    assign y_lo = (PACKET_BYTES == 4) ? b2 : ps2_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delta_x      <= '0;
            delta_y      <= '0;
            wheel        <= '0;
            buttons      <= '0;
            ovf          <= '0;
            packet_valid <= 1'b0;
        end else begin
            packet_valid <= pkt_done;
            if (pkt_done) begin
                delta_x <= {b0_xs, b1};
                delta_y <= {b0_ys, y_lo};
                buttons <= b0_btn;
                ovf     <= b0_ovf;
                wheel   <= (PACKET_BYTES == 4) ? ps2_byte[3:0] : 4'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Cursor position (N+2)
    // ------------------------------------------------------------------
    function automatic logic [POS_W-1:0] clamp_axis(
        input logic signed [SW-1:0] v,
        input logic [POS_W-1:0]     lim
    );
        if (v[SW-1])                         return '0;
        else if (v > $signed({2'b00, lim}))  return lim;
        else                                 return v[POS_W-1:0];
    endfunction

    logic signed [SW-1:0] dx_ext, dy_ext, sum_x, sum_y;

    // An overflowed axis carries garbage; it moves the cursor by zero.
    assign dx_ext = ovf[0] ? '0 : {{(SW-9){delta_x[8]}}, delta_x};
    assign dy_ext = ovf[1] ? '0 : {{(SW-9){delta_y[8]}}, delta_y};
    assign sum_x  = $signed({2'b00, pos_x}) + dx_ext;
    assign sum_y  = (INVERT_Y != 0) ? $signed({2'b00, pos_y}) - dy_ext
                                    : $signed({2'b00, pos_y}) + dy_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x      <= X_CTR;
            pos_y      <= Y_CTR;
            pos_update <= 1'b0;
        end else if (clear) begin
            // re-centre silently, cancelling any update due this cycle
            pos_x      <= X_CTR;
            pos_y      <= Y_CTR;
            pos_update <= 1'b0;
        end else begin
            pos_update <= packet_valid;
            if (packet_valid) begin
                pos_x <= clamp_axis(sum_x, X_LIM);
                pos_y <= clamp_axis(sum_y, Y_LIM);
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_tracker
//
// Directed bench for ps2_mouse_tracker. dut_a is 3-byte mode and dut_w is
// 4-byte wheel mode. Both use a 16-cycle inter-byte timeout. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_tracker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut_a (3-byte)
    logic [7:0] a_byte;
    logic       a_en, a_clr;
    logic [8:0] a_dx, a_dy;
    logic [3:0] a_wheel;
    logic [2:0] a_btn;
    logic [1:0] a_ovf;
    logic       a_pv, a_pu, a_se;
    logic [9:0] a_px, a_py;

    // dut_w (4-byte wheel)
    logic [7:0] w_byte;
    logic       w_en, w_clr;
    logic [8:0] w_dx, w_dy;
    logic [3:0] w_wheel;
    logic [2:0] w_btn;
    logic [1:0] w_ovf;
    logic       w_pv, w_pu, w_se;
    logic [9:0] w_px, w_py;

    ps2_mouse_tracker #(.PACKET_BYTES(3), .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .ps2_byte(a_byte), .ps2_byte_en(a_en),
        .clear(a_clr), .delta_x(a_dx), .delta_y(a_dy), .wheel(a_wheel),
        .buttons(a_btn), .ovf(a_ovf), .packet_valid(a_pv), .pos_x(a_px),
        .pos_y(a_py), .pos_update(a_pu), .sync_err(a_se)
    );

    ps2_mouse_tracker #(.PACKET_BYTES(4), .TIMEOUT_CYCLES(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .ps2_byte(w_byte), .ps2_byte_en(w_en),
        .clear(w_clr), .delta_x(w_dx), .delta_y(w_dy), .wheel(w_wheel),
        .buttons(w_btn), .ovf(w_ovf), .packet_valid(w_pv), .pos_x(w_px),
        .pos_y(w_py), .pos_update(w_pu), .sync_err(w_se)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present one byte for exactly one cycle. Returns at the falling edge
    // just after the byte was sampled. Consecutive calls produce
    // back-to-back strobes.
    task automatic send_a(input logic [7:0] b);
        a_byte = b;
        a_en   = 1'b1;
        @(negedge clk);
        a_en   = 1'b0;
    endtask

    task automatic send_w(input logic [7:0] b);
        w_byte = b;
        w_en   = 1'b1;
        @(negedge clk);
        w_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int se_cnt, pv_cnt;
        logic [9:0] clamp_exp [4];
        clamp_exp = '{10'd63, 10'd0, 10'd0, 10'd0};

        rst_n = 1'b0;
        a_byte = '0; a_en = 1'b0; a_clr = 1'b0;
        w_byte = '0; w_en = 1'b0; w_clr = 1'b0;
        repeat (2) @(negedge clk);

        // ---- reset state ----
        check("rst pos_x", a_px, 319);
        check("rst pos_y", a_py, 239);
        check("rst delta_x", a_dx, 0);
        check("rst pv/pu/se", {a_pv, a_pu, a_se}, 0);
        check("rst w pos", {w_px, w_py}, {10'd319, 10'd239});
        rst_n = 1'b1;
        @(negedge clk);

        // ---- basic 3-byte packet ----
        send_a(8'h09); send_a(8'h05); send_a(8'h03);
        check("basic pv", a_pv, 1);
        check("basic dx", a_dx, 9'd5);
        check("basic dy", a_dy, 9'd3);
        check("basic buttons", a_btn, 3'b001);
        check("basic ovf/wheel", {a_ovf, a_wheel}, 0);
        check("basic pos not yet", {a_pu, a_px}, {1'b0, 10'd319});
        @(negedge clk);
        check("basic pu", a_pu, 1);
        check("basic pv drop", a_pv, 0);
        check("basic pos", {a_px, a_py}, {10'd324, 10'd236});
        @(negedge clk);
        check("basic pu drop", a_pu, 0);

        // ---- clear re-centres, packet outputs kept ----
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        check("clr pos", {a_px, a_py}, {10'd319, 10'd239});
        check("clr no pulses", {a_pu, a_se}, 0);
        check("clr dx kept", a_dx, 9'd5);

        // ---- clamp at 0 in X, at Y_MAX in Y ----
        for (int i = 0; i < 4; i++) begin
            send_a(8'h18); send_a(8'h00); send_a(8'h00);
            check("clamp dx", a_dx, 9'h100);
            @(negedge clk);
            check("clamp pos_x", a_px, clamp_exp[i]);
        end
        send_a(8'h28); send_a(8'h00); send_a(8'h00);
        check("clamp dy", a_dy, 9'h100);
        @(negedge clk);
        check("clamp pos_y", {a_px, a_py}, {10'd0, 10'd479});

        // ---- sync error on bad byte 0 ----
        send_a(8'h00);
        check("sync se", a_se, 1);
        check("sync no pv", a_pv, 0);
        @(negedge clk);
        check("sync se drop", a_se, 0);
        send_a(8'h08); send_a(8'h01); send_a(8'h01);
        check("sync pkt", {a_pv, a_dx, a_dy}, {1'b1, 9'd1, 9'd1});
        @(negedge clk);
        check("sync pos", {a_px, a_py}, {10'd1, 10'd478});

        // ---- timeout ----
        send_a(8'h08); send_a(8'h05);
        se_cnt = 0; pv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            se_cnt += int'(a_se);
            pv_cnt += int'(a_pv);
        end
        check("timeout se count", se_cnt, 1);
        check("timeout pv count", pv_cnt, 0);
        send_a(8'h08); send_a(8'h02); send_a(8'h00);
        check("timeout next pkt", {a_pv, a_dx}, {1'b1, 9'd2});
        @(negedge clk);
        check("timeout pos", {a_px, a_py}, {10'd3, 10'd478});

        // ---- strobe arriving on the limit cycle is accepted ----
        send_a(8'h08);
        se_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            se_cnt += int'(a_se);
        end
        send_a(8'h04);
        se_cnt += int'(a_se);
        send_a(8'h06);
        check("limit se count", se_cnt, 0);
        check("limit pkt", {a_pv, a_dx, a_dy}, {1'b1, 9'd4, 9'd6});
        @(negedge clk);
        check("limit pos", {a_px, a_py}, {10'd7, 10'd472});

        // ---- clear wins over pending position update ----
        send_a(8'h08); send_a(8'h0A); send_a(8'h00);
        check("pend pv", a_pv, 1);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        check("pend no pu", a_pu, 0);
        check("pend pos", {a_px, a_py}, {10'd319, 10'd239});

        // ---- clear coincident with a byte mid-packet ----
        send_a(8'h08); send_a(8'h05);
        a_byte = 8'h07; a_en = 1'b1; a_clr = 1'b1;
        @(negedge clk);
        a_en = 1'b0; a_clr = 1'b0;
        check("midclr pulses", {a_pv, a_pu, a_se}, 0);
        check("midclr pos", {a_px, a_py}, {10'd319, 10'd239});
        check("midclr dx kept", a_dx, 9'd10);
        send_a(8'h00);
        check("midclr in B0", a_se, 1);

        // ---- reset mid-packet ----
        send_a(8'h08); send_a(8'h05);
        rst_n = 1'b0;
        #1;
        check("midrst dx", a_dx, 0);
        check("midrst btn/ovf", {a_btn, a_ovf}, 0);
        check("midrst pos", {a_px, a_py}, {10'd319, 10'd239});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_a(8'h01);
        check("midrst needs b0", {a_se, a_pv}, 2'b10);
        send_a(8'h08); send_a(8'h01); send_a(8'h00);
        check("midrst pkt", {a_pv, a_dx}, {1'b1, 9'd1});

        // ---- wheel mode with X overflow ----
        send_w(8'h48); send_w(8'h10); send_w(8'h00); send_w(8'h0F);
        check("wheel pv", w_pv, 1);
        check("wheel val", w_wheel, 4'hF);
        check("wheel ovf", w_ovf, 2'b01);
        check("wheel dx", w_dx, 9'h010);
        @(negedge clk);
        check("wheel ovf pos", {w_pu, w_px, w_py}, {1'b1, 10'd319, 10'd239});
        send_w(8'h08); send_w(8'h03); send_w(8'h02); send_w(8'h01);
        check("wheel pkt2", {w_pv, w_wheel, w_dx, w_dy}, {1'b1, 4'd1, 9'd3, 9'd2});
        @(negedge clk);
        check("wheel pos2", {w_px, w_py}, {10'd322, 10'd237});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
